// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester, round-robin arbiter in front of a single data memory port.
//
// Each transaction passes through IDLE -> ISSUE -> RESP. Accesses that fail the
// size/alignment/bounds check go IDLE -> RESP and never touch memory.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   reqN, weN, sizeN      : request valid (held until ackN), store/load, size (11 w, 10 h, 01 b)
//   addrN, wdataN         : byte address, right-justified store data
//   ackN, errN, rdataN    : one-cycle completion, reject flag, load result (held until next ackN)
//   mem_write, mem_read   : size-encoded strobes, only nonzero in ISSUE
//   mem_address,
//   mem_write_data        : latched address / store data
//   mem_read_data         : memory load data, updated at the negedge of the ISSUE cycle
//   busy, grant           : FSM not idle, index of the requester being served
module dmem_arbiter #(
    parameter logic [31:0] SIZE = 32'h8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [1:0]  size0,
    input  logic [1:0]  size1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [1:0]  mem_write,
    output logic [1:0]  mem_read,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        busy,
    output logic        grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t      state_q, state_d;
    logic        ptr_q;
    logic        grant_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata0_q, rdata1_q;

    // Winner selection: the pointer only matters when both requesters are asking.
    logic        any_req;
    logic        winner;
    logic        w_we;
    logic [1:0]  w_size;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [2:0]  w_bytes;
    logic        w_err;

    assign any_req = req0 | req1;
    assign winner  = (req0 & req1) ? ptr_q : req1;
    assign w_we    = winner ? we1    : we0;
    assign w_size  = winner ? size1  : size0;
    assign w_addr  = winner ? addr1  : addr0;
    assign w_wdata = winner ? wdata1 : wdata0;

    always_comb begin
        w_bytes = 3'd0;
        case (w_size)
            2'b11:   w_bytes = 3'd4;
            2'b10:   w_bytes = 3'd2;
            2'b01:   w_bytes = 3'd1;
            default: w_bytes = 3'd0;
        endcase
    end

    // 33-bit end-address sum so an access near 0xFFFFFFFF cannot wrap past the check.
    always_comb begin
        w_err = 1'b0;
        if (w_size == 2'b00)                                    w_err = 1'b1;
        if (w_addr >= SIZE)                                     w_err = 1'b1;
        if (({1'b0, w_addr} + {30'b0, w_bytes}) > {1'b0, SIZE}) w_err = 1'b1;
        if (w_size == 2'b11 && w_addr[1:0] != 2'b00)            w_err = 1'b1;
        if (w_size == 2'b10 && w_addr[0])                       w_err = 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = w_err ? RESP : ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, arbitration pointer and per-requester read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= 1'b0;
            grant_q  <= 1'b0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (state_q == IDLE && any_req) begin
                ptr_q   <= ~winner;
                grant_q <= winner;
                we_q    <= w_we;
                size_q  <= w_size;
                addr_q  <= w_addr;
                wdata_q <= w_wdata;
                err_q   <= w_err;
                if (w_err) begin
                    if (winner) rdata1_q <= '0;
                    else        rdata0_q <= '0;
                end
            end
            // Memory drives its data at the negedge of ISSUE; take it on the closing edge.
            if (state_q == ISSUE && !we_q) begin
                if (grant_q) rdata1_q <= mem_read_data;
                else         rdata0_q <= mem_read_data;
            end
        end
    end

    // Outputs
    always_comb begin
        busy           = (state_q != IDLE);
        grant          = grant_q;
        mem_write      = 2'b00;
        mem_read       = 2'b00;
        mem_address    = addr_q;
        mem_write_data = wdata_q;
        ack0           = 1'b0;
        ack1           = 1'b0;
        if (state_q == ISSUE) begin
            if (we_q) mem_write = size_q;
            else      mem_read  = size_q;
        end
        if (state_q == RESP) begin
            ack0 = ~grant_q;
            ack1 = grant_q;
        end
        err0   = ack0 & err_q;
        err1   = ack1 & err_q;
        rdata0 = rdata0_q;
        rdata1 = rdata1_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares on every ack; a big-endian memory model
// answers the DUT strobes.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [1:0]  size0 = 0, size1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic        ack0, ack1, err0, err1, busy, grant;
    logic [31:0] rdata0, rdata1, mem_address, mem_write_data;
    logic [31:0] mem_read_data = 0;
    logic [1:0]  mem_write, mem_read;

    dmem_arbiter #(.SIZE(32'h8000)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .size0(size0), .size1(size1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;   // expected ack cycle, -1 when arbitration makes it variable
    } exp_t;

    exp_t q0[$], q1[$];
    int   order_q[$];
    int   checks = 0, errors = 0;
    int   cyc = 0;
    int   strobes = 0;
    logic [7:0] mem [0:32767];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Big-endian memory model, acts at the negedge of the ISSUE cycle.
    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_address <= 32'h7FFC || mem_write == 2'b01 || mem_read == 2'b01 ||
                (mem_address <= 32'h7FFE && (mem_write == 2'b10 || mem_read == 2'b10))) begin
                case (mem_write)
                    2'b11: begin
                        mem[mem_address[14:0]]       = mem_write_data[31:24];
                        mem[mem_address[14:0] + 15'd1] = mem_write_data[23:16];
                        mem[mem_address[14:0] + 15'd2] = mem_write_data[15:8];
                        mem[mem_address[14:0] + 15'd3] = mem_write_data[7:0];
                    end
                    2'b10: begin
                        mem[mem_address[14:0]]       = mem_write_data[15:8];
                        mem[mem_address[14:0] + 15'd1] = mem_write_data[7:0];
                    end
                    2'b01: mem[mem_address[14:0]] = mem_write_data[7:0];
                    default: ;
                endcase
                case (mem_read)
                    2'b11: mem_read_data = {mem[mem_address[14:0]], mem[mem_address[14:0] + 15'd1],
                                            mem[mem_address[14:0] + 15'd2], mem[mem_address[14:0] + 15'd3]};
                    2'b10: mem_read_data = {16'h0, mem[mem_address[14:0]], mem[mem_address[14:0] + 15'd1]};
                    2'b01: mem_read_data = {24'h0, mem[mem_address[14:0]]};
                    default: ;
                endcase
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic prev0, prev1;
        exp_t e;
        prev0 = 0;
        prev1 = 0;
        forever begin
            @(negedge clk);
            if (mem_read != 2'b00 || mem_write != 2'b00) strobes++;
            for (int p = 0; p < 2; p++) begin
                logic a, pr, er;
                logic [31:0] rd;
                a  = p ? ack1 : ack0;
                pr = p ? prev1 : prev0;
                er = p ? err1 : err0;
                rd = p ? rdata1 : rdata0;
                if (a) begin
                    chk($sformatf("ack%0d_pulse", p), {31'b0, pr}, 32'd0);
                    chk($sformatf("grant_at_ack%0d", p), {31'b0, grant}, p);
                    if (order_q.size() > 0) chk("grant_order", p, order_q.pop_front());
                    if ((p ? q1.size() : q0.size()) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack%0d: got ack with empty queue, expected none", p);
                    end else begin
                        e = p ? q1.pop_front() : q0.pop_front();
                        chk($sformatf("err%0d", p), {31'b0, er}, {31'b0, e.err});
                        chk($sformatf("rdata%0d", p), rd, e.rdata);
                        if (e.cyc >= 0) chk($sformatf("latency%0d", p), cyc, e.cyc);
                    end
                end
            end
            prev0 = ack0;
            prev1 = ack1;
        end
    end

    // Issue one request and hold it until acked; lat = 3 legal, 2 error, -1 unchecked.
    task automatic do_req(input int p, input logic we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic eerr, input logic [31:0] erd, input int lat,
                          input bit scramble);
        exp_t e;
        bit   got;
        e.err   = eerr;
        e.rdata = erd;
        e.cyc   = (lat < 0) ? -1 : cyc + lat - 1;
        if (p == 0) begin
            q0.push_back(e);
            we0 = we; size0 = sz; addr0 = a; wdata0 = wd; req0 = 1;
        end else begin
            q1.push_back(e);
            we1 = we; size1 = sz; addr1 = a; wdata1 = wd; req1 = 1;
        end
        if (scramble) begin
            @(posedge clk); #1;
            if (p == 0) begin addr0 = ~a; we0 = ~we; size0 = 2'b01; wdata0 = ~wd; end
            else        begin addr1 = ~a; we1 = ~we; size1 = 2'b01; wdata1 = ~wd; end
            #1;
            chk("mem_address_latched", mem_address, a);
            chk("mem_read_latched", {30'b0, mem_read}, {30'b0, sz});
        end
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = (p == 0) ? ack0 : ack1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout_ack%0d: got no ack, expected ack within 30 cycles", p);
        end
        @(posedge clk); #1;
        if (p == 0) req0 = 0; else req1 = 0;
    endtask

    initial begin
        int s0;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_grant", {31'b0, grant}, 0);
        chk("rst_ack", {30'b0, ack1, ack0}, 0);
        chk("rst_err", {30'b0, err1, err0}, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_strobes", {28'b0, mem_write, mem_read}, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_wdata", mem_write_data, 0);
        rst_n = 1;

        // Both requesters held: grants alternate 0,1,0,1
        order_q.push_back(0); order_q.push_back(1);
        order_q.push_back(0); order_q.push_back(1);
        fork
            begin
                do_req(0, 1, 2'b11, 32'h20, 32'hA5A5A5A5, 0, 32'h0, -1, 0);
                do_req(0, 0, 2'b11, 32'h20, 32'h0, 0, 32'hA5A5A5A5, -1, 0);
            end
            begin
                do_req(1, 0, 2'b01, 32'h40, 32'h0, 0, 32'h0, -1, 0);
                do_req(1, 0, 2'b01, 32'h40, 32'h0, 0, 32'h0, -1, 0);
            end
        join

        // Store then load word; store leaves rdata unchanged
        do_req(0, 1, 2'b11, 32'h10, 32'hDEADBEEF, 0, 32'hA5A5A5A5, 3, 0);
        do_req(0, 0, 2'b11, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3, 0);

        // Half/byte loads after word store (big-endian layout)
        do_req(1, 1, 2'b11, 32'h10, 32'h11223344, 0, 32'h0, 3, 0);
        do_req(1, 0, 2'b10, 32'h12, 32'h0, 0, 32'h00003344, 3, 0);
        do_req(1, 0, 2'b01, 32'h11, 32'h0, 0, 32'h00000022, 3, 0);

        // Last legal word / byte of memory
        do_req(1, 1, 2'b11, 32'h7FFC, 32'hCAFEF00D, 0, 32'h22, 3, 0);
        do_req(1, 0, 2'b01, 32'h7FFF, 32'h0, 0, 32'h0000000D, 3, 0);
        do_req(1, 0, 2'b11, 32'h7FFC, 32'h0, 0, 32'hCAFEF00D, 3, 0);

        // Rejected accesses: 2-cycle, rdata cleared, no memory strobe
        s0 = strobes;
        do_req(0, 0, 2'b11, 32'h8000, 32'h0, 1, 32'h0, 2, 0);
        do_req(0, 0, 2'b11, 32'h6, 32'h0, 1, 32'h0, 2, 0);
        do_req(0, 0, 2'b10, 32'h3, 32'h0, 1, 32'h0, 2, 0);
        do_req(0, 0, 2'b00, 32'h0, 32'h0, 1, 32'h0, 2, 0);
        do_req(0, 0, 2'b01, 32'hFFFFFFFF, 32'h0, 1, 32'h0, 2, 0);
        do_req(0, 1, 2'b11, 32'h7FFE, 32'h12345678, 1, 32'h0, 2, 0);
        do_req(0, 0, 2'b10, 32'h7FFF, 32'h0, 1, 32'h0, 2, 0);
        chk("no_strobe_on_error", strobes, s0);

        // Inputs changed while busy do not disturb the latched transaction
        do_req(0, 0, 2'b11, 32'h10, 32'h0, 0, 32'h11223344, 3, 1);

        // Reset during ISSUE: everything clears asynchronously, no ack
        addr1 = 32'h10; size1 = 2'b11; we1 = 0; req1 = 1;
        @(posedge clk); #2;
        chk("issue_busy", {31'b0, busy}, 1);
        chk("issue_mem_read", {30'b0, mem_read}, 32'd3);
        rst_n = 0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_mem_read", {30'b0, mem_read}, 0);
        chk("midrst_mem_address", mem_address, 0);
        chk("midrst_grant", {31'b0, grant}, 0);
        chk("midrst_rdata", rdata0 | rdata1, 0);
        req1 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        do_req(1, 0, 2'b01, 32'h13, 32'h0, 0, 32'h00000044, 3, 0);

        repeat (4) @(posedge clk);
        chk("leftover_expected", q0.size() + q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 32'h8000, data memory size in bytes, used for the bounds check.
REQ-002 SHALL have port clk, input, 1 bit, single clock; all state changes on posedge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous, active-low reset.
REQ-004 SHALL have ports req0/req1, input, 1 bit each, request valid per requester N; held until ackN.
REQ-005 SHALL have ports we0/we1, input, 1 bit each, 1=store, 0=load.
REQ-006 SHALL have ports size0/size1, input, 2 bits each, access size: 11=word, 10=half, 01=byte, 00=illegal.
REQ-007 SHALL have ports addr0/addr1, input, 32 bits each, byte address.
REQ-008 SHALL have ports wdata0/wdata1, input, 32 bits each, store data, right-justified for half and byte.
REQ-009 SHALL have ports ack0/ack1, output, 1 bit each, one-cycle completion pulse.
REQ-010 SHALL have ports err0/err1, output, 1 bit each, valid with ackN; 1=access rejected.
REQ-011 SHALL have ports rdata0/rdata1, output, 32 bits each, load result, valid with ackN, held until next ackN.
REQ-012 SHALL have port mem_write, output, 2 bits, memory write-size strobe (encoded as sizeN; 00=none).
REQ-013 SHALL have port mem_read, output, 2 bits, memory read-size strobe (encoded as sizeN; 00=none).
REQ-014 SHALL have port mem_address, output, 32 bits, memory byte address.
REQ-015 SHALL have port mem_write_data, output, 32 bits, memory store data.
REQ-016 SHALL have port mem_read_data, input, 32 bits, memory load data; the memory updates it at the negedge of the issue cycle.
REQ-017 SHALL have port busy, output, 1 bit, high whenever state != IDLE.
REQ-018 SHALL have port grant, output, 1 bit, index of the requester currently being served.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE and RESP.
REQ-020 In IDLE with any reqN high, SHALL latch we/size/addr/wdata of the winner, set grant, and move to ISSUE (or to RESP with error, per REQ-023).
REQ-021 SHALL arbitrate round-robin: a pointer, reset to 0, selects the winner when both requests are high; after each grant the pointer moves to the other requester; a single requester always wins.
REQ-022 In ISSUE, SHALL drive mem_address/mem_write_data from the latch; mem_write=size if we else 00; mem_read=size if !we else 00; all mem_* strobes 00 in every other state; next state RESP.
REQ-023 SHALL flag error and skip ISSUE (no memory strobe) when size=00, addr>=SIZE, addr+bytes>SIZE, word addr[1:0]!=0, or half addr[0]!=0.
REQ-024 On the posedge ending ISSUE, SHALL capture mem_read_data into rdataN for loads; stores leave rdataN unchanged; errors set rdataN=0.
REQ-025 In RESP, SHALL assert ackN for exactly one cycle, with errN valid; next state IDLE.
REQ-026 Transaction latency SHALL be 3 cycles from request sampled to ack for a legal access, and 2 cycles for an error.
REQ-027 A requester may present a new request in the cycle after ack; requests arriving during ISSUE/RESP SHALL wait, with no loss and no reordering per requester.
REQ-028 Input changes while busy SHALL NOT affect the transaction in flight.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, pointer=0, grant=0, busy=0, ack0/1=0, err0/1=0, rdata0/1=0, mem_write=00, mem_read=00, mem_address=0, mem_write_data=0.
REQ-030 Reset mid-transaction SHALL abandon it with no ack; the memory contents are not rolled back.

Verification
REQ-031 Scenario: req0 store word 0xDEADBEEF @0x10, then load word @0x10 -> ack0 after 3 cycles each; rdata0=0xDEADBEEF, err0=0.
REQ-032 Scenario: req0 and req1 both held from reset -> grants alternate 0,1,0,1; each ack is exactly one cycle.
REQ-033 Scenario: load half @0x12 after store word 0x11223344 @0x10 -> rdata=0x00003344; load byte @0x11 -> 0x00000022.
REQ-034 Scenario: load word @0x8000, word @0x6, half @0x3, size=00 -> each gives err=1 and rdata=0 after 2 cycles; mem_read/mem_write stay 00.
REQ-035 Scenario: rst_n low during ISSUE -> all outputs 0 asynchronously, no ack; after release a new req1 is served normally.
REQ-036 Scenario: addr0 changed while busy -> mem_address keeps the latched value.
